sram_controller: RTL
====================

SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-003 The block SHALL have port wr_en, input, 1 bit: word write request from the memory stage.
REQ-004 The block SHALL have port rd_en, input, 1 bit: word read request from the memory stage.
REQ-005 The block SHALL have port address, input, 32 bits: byte address of the word.
REQ-006 The block SHALL have port write_data, input, 32 bits: store data.
REQ-007 The block SHALL have port read_data, output, 32 bits: load data.
REQ-008 The block SHALL have port ready, output, 1 bit: access complete or no access pending; the pipeline freezes on ~ready.
REQ-009 The block SHALL have port SRAM_DQ, inout, 16 bits: SRAM data bus.
REQ-010 The block SHALL have port SRAM_ADDR, output, 18 bits: SRAM halfword address.
REQ-011 The block SHALL have ports SRAM_UB_N, SRAM_LB_N, SRAM_CE_N, SRAM_OE_N and SRAM_WE_N, each output, 1 bit, active-low SRAM controls.

Function
REQ-012 The FSM SHALL have states IDLE, LO, HI, WAIT1, WAIT2 and DONE; the transitions SHALL be IDLE->LO when wr_en|rd_en, LO->HI->WAIT1->WAIT2->DONE unconditionally, and DONE->IDLE unconditionally.
REQ-013 When wr_en and rd_en are both high in IDLE, the write SHALL win; the latched operation type SHALL be held until DONE.
REQ-014 The ready output SHALL be combinational: in IDLE it is ~(wr_en|rd_en); in LO through WAIT2 it is 0; in DONE it is 1.
REQ-015 A request accepted at cycle C0 SHALL produce ready=1 at cycle C5, giving a fixed access latency of 6 cycles with 5 frozen cycles.
REQ-016 In DONE, ready SHALL be 1 even if the request is still asserted, and no new access starts until IDLE is re-entered.
REQ-017 The address SHALL be latched in IDLE on acceptance. Word index w = address[31:2]; LO drives SRAM_ADDR = {w[16:0],1'b0}; HI drives SRAM_ADDR = {w[16:0],1'b1}; other states drive 0.
REQ-018 SRAM_WE_N SHALL be 0 only in LO and HI of a write, and 1 otherwise.
REQ-019 SRAM_DQ SHALL carry write_data[15:0] in LO and write_data[31:16] in HI of a write, and high-Z in all other cycles.
REQ-020 For a read, SRAM_DQ SHALL be sampled at the end of LO into read_data[15:0] and at the end of HI into read_data[31:16].
REQ-021 read_data SHALL hold its value until the next read overwrites it; writes SHALL NOT alter it.
REQ-022 SRAM_UB_N, SRAM_LB_N, SRAM_CE_N and SRAM_OE_N SHALL be tied 0.
REQ-023 Address bits above w[16] SHALL be ignored, so the SRAM address space wraps at 2^17 words.

Reset
REQ-024 On a clk edge with rst=0, the FSM SHALL go to IDLE, read_data SHALL become 0, and the latched address, data and operation SHALL be cleared.
REQ-025 Reset mid-access SHALL abort the access with no further SRAM_WE_N pulse; SRAM_DQ SHALL be high-Z from the next cycle, and ready follows REQ-014 for IDLE.

Configuration
REQ-026 With macro SRAM_ADDR_OFFSET_EN defined, the word index SHALL be w = (address - 1024)[31:2], mapping data memory base 1024 to SRAM word 0.
REQ-027 Without SRAM_ADDR_OFFSET_EN, w = address[31:2] and there is no subtraction.

Verification
REQ-028 Write 0xDEADBEEF to address 8 (offset disabled) -> LO: SRAM_ADDR=4, DQ=0xBEEF, WE_N=0; HI: SRAM_ADDR=5, DQ=0xDEAD, WE_N=0; ready=0 for C0–C4 and 1 at C5.
REQ-029 Read address 8 with the SRAM model holding 0xBEEF at 4 and 0xDEAD at 5 -> read_data=0xDEADBEEF at C5, held after rd_en drops.
REQ-030 wr_en=1 and rd_en=1 together at address 0 with data 0x12345678 -> write performed (WE_N low in LO and HI), read_data unchanged.
REQ-031 Reset driven low during HI of a write -> next cycle IDLE, WE_N=1, DQ high-Z, read_data=0; with no request, ready=1.
REQ-032 rd_en held high across DONE -> ready=1 in DONE, IDLE next cycle, and a new access starts; two back-to-back reads take 12 cycles in total.
REQ-033 SRAM_ADDR_OFFSET_EN defined, read address 1028 -> SRAM_ADDR=2 then 3.

Source files
------------

// File: rtl/sram_controller.sv
// sram_controller: 32-bit word access to a 16-bit asynchronous SRAM as two halfword cycles with a fixed 6-cycle latency.
// Optional macro SRAM_ADDR_OFFSET_EN maps byte address 1024 to SRAM word 0.
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_WE_N
);

    typedef enum logic [2:0] {IDLE, LO, HI, WAIT1, WAIT2, DONE} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        req;
    logic [31:0] word_addr;
    logic [16:0] word_q;
    logic [31:0] wdata_q;
    logic        wr_op_q;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        unused_addr_bits;

    assign req = wr_en | rd_en;

`ifdef SRAM_ADDR_OFFSET_EN
    assign word_addr = address - 32'd1024;
`else
    assign word_addr = address;
`endif

    // Only 2^17 words exist; upper index bits and byte offset are dropped.
    assign unused_addr_bits = ^{word_addr[31:19], word_addr[1:0]};

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            word_q    <= '0;
            wdata_q   <= '0;
            wr_op_q   <= 1'b0;
            read_data <= '0;
        end else begin
            if (state == IDLE && req) begin
                word_q  <= word_addr[18:2];
                wdata_q <= write_data;
                wr_op_q <= wr_en;
            end
            // Read halves are captured at the end of the cycle that addressed them.
            if (state == LO && !wr_op_q) begin
                read_data[15:0] <= SRAM_DQ;
            end
            if (state == HI && !wr_op_q) begin
                read_data[31:16] <= SRAM_DQ;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        SRAM_ADDR = '0;
        SRAM_WE_N = 1'b1;
        dq_oe     = 1'b0;
        dq_out    = '0;
        case (state)
            IDLE: begin
                ready = ~req;
                if (req) begin
                    state_nxt = LO;
                end
            end
            LO: begin
                state_nxt = HI;
                SRAM_ADDR = {word_q, 1'b0};
                SRAM_WE_N = ~wr_op_q;
                dq_oe     = wr_op_q;
                dq_out    = wdata_q[15:0];
            end
            HI: begin
                state_nxt = WAIT1;
                SRAM_ADDR = {word_q, 1'b1};
                SRAM_WE_N = ~wr_op_q;
                dq_oe     = wr_op_q;
                dq_out    = wdata_q[31:16];
            end
            WAIT1: state_nxt = WAIT2;
            WAIT2: state_nxt = DONE;
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SRAM_DQ   = dq_oe ? dq_out : 16'bz;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule
